snake_dir_ctrl: RTL and testbench

//   Upstream input stage for the Snake core: conditions four raw direction buttons and drives its l/r/u/d inputs.

---
 rtl/snake_dir_ctrl.sv | 159 +++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// Snake direction input stage: 2-flop sync + debounce per button, reversal/repeat filter, 2-deep turn queue.
// Optional pause button and output enabled by defining DIR_PAUSE_EN.
module snake_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_l,
    input  logic btn_r,
    input  logic btn_u,
    input  logic btn_d,
`ifdef DIR_PAUSE_EN
    input  logic btn_p,
    output logic paused,
`endif
    input  logic tick,
    output logic l,
    output logic r,
    output logic u,
    output logic d,
    output logic q_full
);

    // Direction codes are chosen so that the reverse heading is the code with bit 0 flipped.
    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_L = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

`ifdef DIR_PAUSE_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_s1, r_s2, r_clean, r_clean_d;
    logic [CNT_W-1:0] r_cnt [NB];
    logic [CNT_W-1:0] w_cnt_next [NB];
    logic [NB-1:0]    w_clean_next;
    logic [NB-1:0]    w_press;

`ifdef DIR_PAUSE_EN
    assign w_raw = {btn_p, btn_d, btn_u, btn_l, btn_r};
`else
    assign w_raw = {btn_d, btn_u, btn_l, btn_r};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_btn
            logic w_diff;
            logic w_done;
            assign w_diff = r_s2[gi] ^ r_clean[gi];
            assign w_done = w_diff && (r_cnt[gi] == CNT_W'(DEBOUNCE_CYCLES - 1));
            assign w_cnt_next[gi]   = (w_diff && !w_done) ? r_cnt[gi] + 1'b1 : '0;
            assign w_clean_next[gi] = w_done ? r_s2[gi] : r_clean[gi];
            assign w_press[gi]      = r_clean[gi] & ~r_clean_d[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_clean   <= '0;
            r_clean_d <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_s1      <= w_raw;
            r_s2      <= r_s1;
            r_clean   <= w_clean_next;
            r_clean_d <= r_clean;
            for (int i = 0; i < NB; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    logic [1:0] r_cur, r_q0, r_q1, r_qcnt;
    logic [3:0] r_out;
    logic       r_qfull;
    logic       w_paused, w_paused_next;

`ifdef DIR_PAUSE_EN
    logic r_paused;
    always_ff @(posedge clk) begin
        if (reset) r_paused <= 1'b0;
        else       r_paused <= w_paused_next;
    end
    assign w_paused      = r_paused;
    assign w_paused_next = r_paused ^ w_press[4];
    assign paused        = r_paused;
`else
    assign w_paused      = 1'b0;
    assign w_paused_next = 1'b0;
`endif

    logic       w_req_valid, w_accept, w_pop, w_push;
    logic [1:0] w_req, w_ref, w_cur_next, w_q0_next, w_q1_next, w_qcnt_next;

    always_comb begin
        w_req_valid = |w_press[3:0];
        if (w_press[2])      w_req = DIR_U;
        else if (w_press[3]) w_req = DIR_D;
        else if (w_press[1]) w_req = DIR_L;
        else                 w_req = DIR_R;

        // Compare against where the snake will be heading once queued turns have been applied.
        case (r_qcnt)
            2'd0:    w_ref = r_cur;
            2'd1:    w_ref = r_q0;
            default: w_ref = r_q1;
        endcase

        w_accept = w_req_valid && !w_paused && (w_req != w_ref) && (w_req != {w_ref[1], ~w_ref[0]});
        w_pop    = tick && (r_qcnt != 2'd0) && !w_paused;
        w_push   = w_accept && ((r_qcnt != 2'd2) || w_pop);

        w_cur_next  = r_cur;
        w_q0_next   = r_q0;
        w_q1_next   = r_q1;
        w_qcnt_next = r_qcnt;
        if (w_pop) begin
            w_cur_next  = r_q0;
            w_q0_next   = r_q1;
            w_qcnt_next = r_qcnt - 2'd1;
        end
        if (w_push) begin
            if (w_qcnt_next == 2'd0) w_q0_next = w_req;
            else                     w_q1_next = w_req;
            w_qcnt_next = w_qcnt_next + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur   <= DIR_R;
            r_q0    <= DIR_R;
            r_q1    <= DIR_R;
            r_qcnt  <= 2'd0;
            r_qfull <= 1'b0;
            r_out   <= 4'b0001;
        end else begin
            r_cur   <= w_cur_next;
            r_q0    <= w_q0_next;
            r_q1    <= w_q1_next;
            r_qcnt  <= w_qcnt_next;
            r_qfull <= (w_qcnt_next == 2'd2);
            r_out   <= w_paused_next ? 4'b0000 : (4'b0001 << w_cur_next);
        end
    end

    assign r      = r_out[0];
    assign l      = r_out[1];
    assign u      = r_out[2];
    assign d      = r_out[3];
    assign q_full = r_qfull;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed self-checking bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4.
// The pause scenario is exercised only when DIR_PAUSE_EN is defined.
module tb_snake_dir_ctrl;

    logic clk = 1'b0;
    logic reset, btn_l, btn_r, btn_u, btn_d, tick;
    logic o_l, o_r, o_u, o_d, o_qfull;
    int   n_cmp = 0;
    int   n_bad = 0;

    localparam logic [3:0] OH_R = 4'b0001;
    localparam logic [3:0] OH_L = 4'b0010;
    localparam logic [3:0] OH_U = 4'b0100;
    localparam logic [3:0] OH_D = 4'b1000;

    always #5 clk = ~clk;

`ifdef DIR_PAUSE_EN
    logic btn_p, o_paused;
`endif

    snake_dir_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(5)) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .btn_u  (btn_u),
        .btn_d  (btn_d),
`ifdef DIR_PAUSE_EN
        .btn_p  (btn_p),
        .paused (o_paused),
`endif
        .tick   (tick),
        .l      (o_l),
        .r      (o_r),
        .u      (o_u),
        .d      (o_d),
        .q_full (o_qfull)
    );

    // Outputs packed as {d,u,l,r}.
    function automatic logic [3:0] dir_now();
        return {o_d, o_u, o_l, o_r};
    endfunction

    task automatic set_btns(input logic [3:0] m);
        {btn_d, btn_u, btn_l, btn_r} = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_btns(4'b0000);
        tick = 1'b0;
`ifdef DIR_PAUSE_EN
        btn_p = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Hold a button mask for 8 clocks, then release and let the release debounce out.
    task automatic press(input logic [3:0] m);
        @(negedge clk);
        set_btns(m);
        repeat (8) @(negedge clk);
        set_btns(4'b0000);
        repeat (8) @(negedge clk);
    endtask

    // One-clock tick; returns on the negedge after the sampling edge.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic chk_dir(input string name, input logic [3:0] exp);
        n_cmp++;
        if (dir_now() !== exp) begin
            n_bad++;
            $display("FAIL %s: dir {d,u,l,r} got %b want %b", name, dir_now(), exp);
        end else
            $display("ok   %s: dir %b", name, dir_now());
    endtask

    task automatic chk_full(input string name, input logic exp);
        n_cmp++;
        if (o_qfull !== exp) begin
            n_bad++;
            $display("FAIL %s: q_full got %b want %b", name, o_qfull, exp);
        end else
            $display("ok   %s: q_full %b", name, o_qfull);
    endtask

    task automatic test_reset();
        do_reset();
        chk_dir("reset_dir", OH_R);
        chk_full("reset_qfull", 1'b0);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            chk_dir("idle_tick", OH_R);
        end
        chk_full("idle_qfull", 1'b0);
    endtask

    task automatic test_debounce();
        do_reset();
        @(negedge clk);
        set_btns(OH_U);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (10) @(negedge clk);
        do_tick();
        chk_dir("glitch_ignored", OH_R);
        press(OH_U);
        chk_dir("held_before_tick", OH_R);
        chk_full("held_one_queued", 1'b0);
        do_tick();
        chk_dir("held_after_tick", OH_U);
    endtask

    task automatic test_reject();
        do_reset();
        press(OH_L);
        press(OH_R);
        chk_full("reject_qfull", 1'b0);
        do_tick();
        chk_dir("reject_dir", OH_R);
    endtask

    task automatic test_queue();
        do_reset();
        press(OH_U);
        press(OH_L);
        chk_full("queue_full", 1'b1);
        chk_dir("queue_no_tick", OH_R);
        press(OH_D);
        chk_full("queue_drop_full", 1'b1);
        do_tick();
        chk_dir("queue_pop1", OH_U);
        chk_full("queue_pop1_qfull", 1'b0);
        do_tick();
        chk_dir("queue_pop2", OH_L);
        do_tick();
        chk_dir("queue_empty_tick", OH_L);
    endtask

    task automatic test_simultaneous();
        do_reset();
        press(OH_U | OH_L);
        chk_full("simul_one_entry", 1'b0);
        press(OH_L);
        chk_full("simul_then_l", 1'b1);
        do_tick();
        chk_dir("simul_pop_u", OH_U);
        do_tick();
        chk_dir("simul_pop_l", OH_L);
    endtask

    // Press lands in the same cycle as a tick while the queue is full.
    task automatic test_back_to_back();
        do_reset();
        press(OH_U);
        press(OH_L);
        chk_full("b2b_full", 1'b1);
        @(negedge clk);
        set_btns(OH_D);
        repeat (6) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk_dir("b2b_pop_u", OH_U);
        chk_full("b2b_still_full", 1'b1);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (8) @(negedge clk);
        do_tick();
        chk_dir("b2b_pop_l", OH_L);
        chk_full("b2b_one_left", 1'b0);
        do_tick();
        chk_dir("b2b_pop_d", OH_D);
    endtask

    task automatic test_reset_mid();
        do_reset();
        press(OH_U);
        press(OH_D);
        press(OH_L);
        chk_full("mid_full", 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_dir("mid_reset_dir", OH_R);
        chk_full("mid_reset_qfull", 1'b0);
        do_tick();
        chk_dir("mid_reset_tick", OH_R);
    endtask

`ifdef DIR_PAUSE_EN
    task automatic press_p();
        @(negedge clk);
        btn_p = 1'b1;
        repeat (8) @(negedge clk);
        btn_p = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_pause();
        do_reset();
        press(OH_U);
        press_p();
        chk_dir("pause_dark", 4'b0000);
        do_tick();
        chk_dir("pause_tick_held", 4'b0000);
        press_p();
        chk_dir("unpause_dir", OH_R);
        do_tick();
        chk_dir("unpause_pop", OH_U);
    endtask
`endif

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        set_btns(4'b0000);
`ifdef DIR_PAUSE_EN
        btn_p = 1'b0;
`endif
        test_reset();
        test_debounce();
        test_reject();
        test_queue();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
`ifdef DIR_PAUSE_EN
        test_pause();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
